// File: rtl/conv2_maxpool_collector_pkg.sv
// Shared constants and types for the conv-layer-2 output collector and its pooling datapath.
package conv2_maxpool_collector_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned CONV2_OUT_DIM = 8;
  localparam int unsigned POOL2_OUT_DIM = 4;
  localparam logic [31:0] CLAMP_MAX     = 32'h0001_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/conv2_maxpool_collector_max3_u.sv
// Combinational unsigned 3-input maximum; tie one input to 0 for a 2-input max of non-negative data.
module conv2_maxpool_collector_max3_u #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] max_c
);

  logic [DATA_W-1:0] ab;

  assign ab    = (a_i > b_i) ? a_i : b_i;
  assign max_c = (ab > c_i) ? ab : c_i;

endmodule

// File: rtl/conv2_maxpool_collector.sv
// Collects one IN_DIM x IN_DIM conv-2 feature map per frame and emits its 2x2/stride-2 max-pooled map on the fly.
module conv2_maxpool_collector #(
  parameter int unsigned DATA_W = conv2_maxpool_collector_pkg::DATA_W,
  parameter int unsigned IN_DIM = conv2_maxpool_collector_pkg::CONV2_OUT_DIM,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk_global,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_invalid,
  input  logic              in_finish,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_index,
  output logic              frame_done,
  output logic              err
);

  import conv2_maxpool_collector_pkg::*;

  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned CNT_W   = $clog2(IN_DIM);
  localparam int unsigned BUF_W   = $clog2(OUT_DIM);

  state_e            state_q;
  logic [CNT_W-1:0]  row_q;
  logic [CNT_W-1:0]  col_q;
  logic [DATA_W-1:0] pair_q;
  logic [DATA_W-1:0] rowbuf_q [OUT_DIM];
  logic              fin_q;

  logic              accept;
  logic              fin_rise;
  logic              last_col;
  logic              last_smp;
  logic [BUF_W-1:0]  buf_sel;
  logic [IDX_W-1:0]  pool_idx;
  logic [DATA_W-1:0] max2_c;
  logic [DATA_W-1:0] max3_c;

  assign accept   = ~in_invalid;
  assign fin_rise = in_finish & ~fin_q;
  assign last_col = (col_q == CNT_W'(IN_DIM - 1));
  assign last_smp = last_col && (row_q == CNT_W'(IN_DIM - 1));
  assign buf_sel  = col_q[CNT_W-1:1];
  assign pool_idx = IDX_W'(32'(row_q >> 1) * OUT_DIM + 32'(col_q >> 1));

  // Horizontal pair max for even rows, full 2x2 window max for odd rows.
  conv2_maxpool_collector_max3_u #(.DATA_W(DATA_W)) u_max2 (
    .a_i   (pair_q),
    .b_i   (in_data),
    .c_i   ('0),
    .max_c (max2_c)
  );

  conv2_maxpool_collector_max3_u #(.DATA_W(DATA_W)) u_max3 (
    .a_i   (rowbuf_q[buf_sel]),
    .b_i   (pair_q),
    .c_i   (in_data),
    .max_c (max3_c)
  );

  // clear beats an in_finish edge, which beats a same-cycle sample.
  always_ff @(posedge clk_global or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      pair_q     <= '0;
      fin_q      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < int'(OUT_DIM); i++) rowbuf_q[i] <= '0;
    end else begin
      fin_q      <= in_finish;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        state_q <= ST_IDLE;
        row_q   <= '0;
        col_q   <= '0;
      end else if (fin_rise && state_q == ST_RUN) begin
        err     <= 1'b1;
        state_q <= ST_IDLE;
        row_q   <= '0;
        col_q   <= '0;
      end else if (accept) begin
        if (!col_q[0]) begin
          pair_q <= in_data;
        end else if (!row_q[0]) begin
          rowbuf_q[buf_sel] <= max2_c;
        end else begin
          out_data  <= max3_c;
          out_index <= pool_idx;
          out_valid <= 1'b1;
        end
        if (last_smp) begin
          state_q    <= ST_IDLE;
          row_q      <= '0;
          col_q      <= '0;
          frame_done <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + CNT_W'(1);
          end else begin
            col_q <= col_q + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/conv2_maxpool_collector.md
Name: conv2_maxpool_collector

Overview:
- Receiver for the conv-layer-2 kernel output stream: accepts one clamped 8x8 feature map per frame, one value per clock whenever the upstream marks it valid.
- Performs 2x2 stride-2 max pooling on the fly and emits a 4x4 pooled map: 16 values with a raster index, then a frame-done pulse.
- One instance sits behind each conv layer 2 kernel instance and feeds the pooled-map store / FC stage.

Parameters:
- DATA_W, 32, sample width; matches the kernel output bus.
- IN_DIM, 8, input map side; must be even.
- OUT_DIM, IN_DIM/2, pooled map side; derived, not overridable.
- IDX_W, 4, width of out_index; equals clog2(OUT_DIM*OUT_DIM).

Ports:
- clk_global  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  conv output sample, range 0..0x00010000, treated as unsigned.
- in_invalid  in  1  1 = no sample this cycle; 0 = in_data valid.
- in_finish  in  1  upstream end-of-map flag; level, may stay high.
- clear  in  1  synchronous frame abort; restarts collection.
- out_data  out  DATA_W  pooled maximum.
- out_valid  out  1  one-cycle strobe qualifying out_data and out_index.
- out_index  out  IDX_W  raster position of the pooled value, row*OUT_DIM+col.
- frame_done  out  1  one-cycle pulse, coincident with the 16th out_valid.
- err  out  1  sticky: in_finish rose while a frame was incomplete.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - row, col and out counters go to 0; state goes to IDLE.
  - pair_reg and the row buffer (OUT_DIM entries) go to 0.
- States:
  - IDLE: no sample accepted yet in this frame. Goes to RUN on the first accepted sample.
  - RUN: goes to IDLE after the IN_DIM*IN_DIM-th accepted sample, or on clear, or on an early in_finish.
- Accept condition: in_invalid=0. The accepted sample is at (row, col). col wraps at IN_DIM-1 and increments row.
- Even row, even col: pair_reg <= in_data.
- Even row, odd col: rowbuf[col>>1] <= max(pair_reg, in_data).
- Odd row, even col: pair_reg <= in_data.
- Odd row, odd col:
  - out_data <= max(rowbuf[col>>1], pair_reg, in_data).
  - out_index <= (row>>1)*OUT_DIM + (col>>1).
  - out_valid <= 1 for exactly one cycle, i.e. latency 1 clock after the accepting edge.
- Gaps: in_invalid=1 cycles hold all state. Gaps of any length, anywhere in the frame, do not change the results.
- Comparison is unsigned over the full DATA_W. On ties either operand may be taken, since the values are equal.
- Frame end:
  - On the accept of sample IN_DIM*IN_DIM-1, frame_done pulses together with the last out_valid.
  - Counters return to 0 and the state to IDLE.
  - A sample arriving the very next cycle is accepted as sample 0 of the next frame; there is no dead cycle.
- in_finish:
  - Only its rising edge is used; it is registered internally for edge detection.
  - Rising edge in IDLE or after a completed frame: ignored.
  - Rising edge in RUN: err <= 1 (sticky until reset), counters cleared, state to IDLE, no frame_done.
  - If a sample is accepted in the same cycle, that sample is discarded.
- clear=1:
  - Clears counters and state the next edge and discards any same-cycle sample.
  - Does not touch err, rowbuf or pair_reg; stale contents are always overwritten before use.
  - clear takes priority over the in_finish edge.
- Reset mid-frame: the partial frame is lost. The next frame after reset release pools correctly.

Decomposition:
- Shared constants file (included by conv stage modules):
  - DATA_W=32, CONV2_OUT_DIM=8, POOL2_OUT_DIM=4.
  - State encodings IDLE=0, RUN=1.
  - Clamp ceiling 'h00010000.
- One natural sub-module: max3_u, a combinational unsigned 3-input max of DATA_W.
  - The 2-input max uses the same block with the third input tied to 0; valid because samples are >=0.
- The row buffer stays inline as a register array.

Test Plan:
- Ramp frame 0..63 row-major, no gaps -> 16 outputs 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63 at indices 0..15; frame_done with the last output; out_valid first high 1 clock after sample 9 is accepted.
- Same ramp with random in_invalid gaps (1-5 cycles) -> identical values and indices; no spurious out_valid.
- All-zero frame except sample 0 = 0x00010000 -> out index 0 = 0x00010000; indices 1..15 = 0.
- Two ramp frames back-to-back, the second starting the cycle after the first frame_done -> 32 outputs, two frame_done pulses, second frame values identical.
- 40 samples, then in_finish rises -> err=1, no frame_done, no further outputs. A following full ramp frame pools correctly and err stays 1.
- Async reset pulled low after 20 samples, released, then a full ramp frame -> correct 16 outputs; all outputs 0 while reset is low.
